// File: rtl/rip_ma_stage.sv
// rtl/rip_ma_stage.sv - rip-cpu memory-access stage: issues at most one data-memory transaction
// at a time, formats load data and drives the register file write port.
module rip_ma_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [4:0]        ex_rd_num,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       ex_store_data,
    output logic              dmem_req,
    input  logic              dmem_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_wstrb,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic [4:0]        ma_rd_num,
    output logic              wen,
    output logic [31:0]       wdata,
    output logic              ma_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              dmem_req_d, dmem_we_d, wen_d, ma_fault_d;
    logic [ADDR_W-1:0] dmem_addr_d;
    logic [3:0]        dmem_wstrb_d;
    logic [31:0]       dmem_wdata_d, wdata_d;
    logic [4:0]        ma_rd_num_d;

    // Load context captured at accept, consumed when the read data returns.
    logic [1:0]        lane, lane_d;
    logic [2:0]        ld_funct3, ld_funct3_d;
    logic [4:0]        ld_rd, ld_rd_d;
    logic              ld_wen, ld_wen_d;
    logic [31:0]       tcnt, tcnt_d;

    logic              accept, is_mem, misaligned, illegal_f3;
    logic [31:0]       rsh, ld_val;

    assign ex_ready = (state == IDLE) && !rst;
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_is_load || ex_is_store;

    always_comb begin
        misaligned = 1'b0;
        illegal_f3 = 1'b0;
        case (ex_funct3[1:0])
            2'd1:    misaligned = ex_result[0];
            2'd2:    misaligned = (ex_result[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (ex_is_load)
            illegal_f3 = !(ex_funct3 == 3'd0 || ex_funct3 == 3'd1 || ex_funct3 == 3'd2 ||
                           ex_funct3 == 3'd4 || ex_funct3 == 3'd5);
        else if (ex_is_store)
            illegal_f3 = (ex_funct3 > 3'd2);
    end

    always_comb begin
        rsh    = dmem_rdata >> {lane, 3'b000};
        ld_val = dmem_rdata;
        case (ld_funct3)
            3'd0:    ld_val = {{24{rsh[7]}}, rsh[7:0]};
            3'd1:    ld_val = {{16{rsh[15]}}, rsh[15:0]};
            3'd4:    ld_val = {24'd0, rsh[7:0]};
            3'd5:    ld_val = {16'd0, rsh[15:0]};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state;
        dmem_req_d   = dmem_req;
        dmem_we_d    = dmem_we;
        dmem_addr_d  = dmem_addr;
        dmem_wstrb_d = dmem_wstrb;
        dmem_wdata_d = dmem_wdata;
        ma_rd_num_d  = ma_rd_num;
        wdata_d      = wdata;
        wen_d        = 1'b0;
        ma_fault_d   = 1'b0;
        lane_d       = lane;
        ld_funct3_d  = ld_funct3;
        ld_rd_d      = ld_rd;
        ld_wen_d     = ld_wen;
        tcnt_d       = tcnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wen_d       = ex_wen && (ex_rd_num != 5'd0);
                        ma_rd_num_d = ex_rd_num;
                        wdata_d     = ex_result;
                    end else if (misaligned || illegal_f3) begin
                        ma_fault_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        dmem_req_d  = 1'b1;
                        dmem_we_d   = ex_is_store;
                        dmem_addr_d = {ex_result[ADDR_W-1:2], 2'b00};
                        lane_d      = ex_result[1:0];
                        ld_funct3_d = ex_funct3;
                        ld_rd_d     = ex_rd_num;
                        ld_wen_d    = ex_wen;
                        if (ex_is_store) begin
                            case (ex_funct3[1:0])
                                2'd0: begin
                                    dmem_wstrb_d = 4'b0001 << ex_result[1:0];
                                    dmem_wdata_d = {4{ex_store_data[7:0]}};
                                end
                                2'd1: begin
                                    dmem_wstrb_d = 4'b0011 << {ex_result[1], 1'b0};
                                    dmem_wdata_d = {2{ex_store_data[15:0]}};
                                end
                                default: begin
                                    dmem_wstrb_d = 4'hF;
                                    dmem_wdata_d = ex_store_data;
                                end
                            endcase
                        end else begin
                            dmem_wstrb_d = 4'h0;
                            dmem_wdata_d = 32'd0;
                        end
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    dmem_req_d = 1'b0;
                    tcnt_d     = 32'd0;
                    state_d    = dmem_we ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    wen_d       = ld_wen && (ld_rd != 5'd0);
                    ma_rd_num_d = ld_rd;
                    wdata_d     = ld_val;
                    state_d     = IDLE;
                end else if (TIMEOUT_CYCLES > 0 && tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    ma_fault_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tcnt_d = tcnt + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wstrb <= 4'h0;
            dmem_wdata <= 32'd0;
            ma_rd_num  <= 5'd0;
            wen        <= 1'b0;
            wdata      <= 32'd0;
            ma_fault   <= 1'b0;
            lane       <= 2'd0;
            ld_funct3  <= 3'd0;
            ld_rd      <= 5'd0;
            ld_wen     <= 1'b0;
            tcnt       <= 32'd0;
        end else begin
            state      <= state_d;
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            dmem_addr  <= dmem_addr_d;
            dmem_wstrb <= dmem_wstrb_d;
            dmem_wdata <= dmem_wdata_d;
            ma_rd_num  <= ma_rd_num_d;
            wen        <= wen_d;
            wdata      <= wdata_d;
            ma_fault   <= ma_fault_d;
            lane       <= lane_d;
            ld_funct3  <= ld_funct3_d;
            ld_rd      <= ld_rd_d;
            ld_wen     <= ld_wen_d;
            tcnt       <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_rip_ma_stage.sv
// tb/tb_rip_ma_stage.sv - directed self-checking bench for rip_ma_stage (timeout of 4 cycles).
module tb_rip_ma_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_wen, ex_is_load, ex_is_store;
    logic [4:0]  ex_rd_num, ma_rd_num;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_result, ex_store_data;
    logic        dmem_req, dmem_ready, dmem_we, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, wdata;
    logic [3:0]  dmem_wstrb;
    logic        wen, ma_fault;

    int checks = 0;
    int failures = 0;

    rip_ma_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd_num(ex_rd_num), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_funct3(ex_funct3),
        .ex_result(ex_result), .ex_store_data(ex_store_data),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .ma_rd_num(ma_rd_num), .wen(wen), .wdata(wdata),
        .ma_fault(ma_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                            input logic we, input logic [31:0] res, input logic [31:0] sd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_rd_num = rd; ex_wen = we; ex_result = res; ex_store_data = sd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL reset_ex_ready got=%b exp=0", ex_ready); end
        checks++; if ({dmem_req, dmem_we, wen, ma_fault} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {dmem_req, dmem_we, wen, ma_fault}); end
        checks++; if ({dmem_addr, dmem_wstrb, dmem_wdata, ma_rd_num, wdata} !== '0) begin failures++; $display("FAIL reset_data got addr=%h strb=%h wd=%h rd=%0d wdata=%h exp=0", dmem_addr, dmem_wstrb, dmem_wdata, ma_rd_num, wdata); end
        rst = 1'b0;
        #1;
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", ex_ready); end
    endtask

    task automatic test_alu();
        drive_op(1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 32'h1234, 32'h0);
        step();
        ex_valid = 1'b0;
        checks++; if ({wen, ma_rd_num, wdata} !== {1'b1, 5'd5, 32'h1234}) begin failures++; $display("FAIL alu_wb got wen=%b rd=%0d wdata=%h exp 1/5/00001234", wen, ma_rd_num, wdata); end
        checks++; if (ex_ready !== 1'b1 || dmem_req !== 1'b0) begin failures++; $display("FAIL alu_ready got ready=%b req=%b exp 1/0", ex_ready, dmem_req); end
        step();
        checks++; if (wen !== 1'b0) begin failures++; $display("FAIL alu_wen_pulse got=%b exp=0", wen); end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b0, 1'b0, 3'd0, 5'd1, 1'b1, 32'hAAAA_0001, 32'h0);
        step();
        drive_op(1'b0, 1'b0, 3'd0, 5'd2, 1'b1, 32'hBBBB_0002, 32'h0);
        checks++; if ({wen, ma_rd_num, wdata} !== {1'b1, 5'd1, 32'hAAAA_0001}) begin failures++; $display("FAIL b2b_first got wen=%b rd=%0d wdata=%h", wen, ma_rd_num, wdata); end
        step();
        drive_op(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 32'hCCCC_0003, 32'h0);
        checks++; if ({wen, ma_rd_num, wdata} !== {1'b1, 5'd2, 32'hBBBB_0002}) begin failures++; $display("FAIL b2b_second got wen=%b rd=%0d wdata=%h", wen, ma_rd_num, wdata); end
        step();
        ex_valid = 1'b0;
        checks++; if (wen !== 1'b0) begin failures++; $display("FAIL b2b_rd0 got wen=%b exp=0", wen); end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wd, input int late);
        int held = 0;
        drive_op(1'b0, 1'b1, f3, 5'd3, 1'b0, a, sd);
        dmem_ready = 1'b0;
        step();
        ex_valid = 1'b0;
        checks++; if ({dmem_we, dmem_addr, dmem_wstrb, dmem_wdata} !== {1'b1, a & 32'hFFFF_FFFC, exp_strb, exp_wd}) begin
            failures++; $display("FAIL %s_fields got we=%b addr=%h strb=%b wd=%h exp addr=%h strb=%b wd=%h", name, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, a & 32'hFFFF_FFFC, exp_strb, exp_wd);
        end
        for (int i = 0; i <= late; i++) begin
            if (dmem_req === 1'b1 && dmem_wstrb === exp_strb && dmem_wdata === exp_wd) held++;
            if (i == late) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        checks++; if (held != late + 1) begin failures++; $display("FAIL %s_hold got=%0d exp=%0d", name, held, late + 1); end
        checks++; if ({dmem_req, wen, ex_ready} !== 3'b001) begin failures++; $display("FAIL %s_done got req/wen/ready=%b exp=001", name, {dmem_req, wen, ex_ready}); end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] rd_word, input logic [31:0] exp);
        drive_op(1'b1, 1'b0, f3, 5'd7, 1'b1, a, 32'hFFFF_FFFF);
        step();
        ex_valid = 1'b0;
        checks++; if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr} !== {1'b1, 1'b0, 4'h0, a & 32'hFFFF_FFFC}) begin
            failures++; $display("FAIL %s_req got req=%b we=%b strb=%b addr=%h", name, dmem_req, dmem_we, dmem_wstrb, dmem_addr);
        end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        step(); step();
        checks++; if ({dmem_req, wen, ex_ready} !== 3'b000) begin failures++; $display("FAIL %s_wait got req/wen/ready=%b exp=000", name, {dmem_req, wen, ex_ready}); end
        dmem_rvalid = 1'b1; dmem_rdata = rd_word;
        step();
        dmem_rvalid = 1'b0;
        checks++; if ({wen, ma_rd_num, wdata, ma_fault} !== {1'b1, 5'd7, exp, 1'b0}) begin
            failures++; $display("FAIL %s_wb got wen=%b rd=%0d wdata=%h fault=%b exp wdata=%h", name, wen, ma_rd_num, wdata, ma_fault, exp);
        end
        step();
        checks++; if (wen !== 1'b0) begin failures++; $display("FAIL %s_wen_pulse got=%b exp=0", name, wen); end
    endtask

    task automatic test_fault(input string name, input logic ld, input logic [2:0] f3, input logic [31:0] a);
        drive_op(ld, !ld, f3, 5'd4, 1'b1, a, 32'h1);
        step();
        ex_valid = 1'b0;
        checks++; if ({ma_fault, wen, dmem_req, ex_ready} !== 4'b1001) begin
            failures++; $display("FAIL %s got fault/wen/req/ready=%b exp=1001", name, {ma_fault, wen, dmem_req, ex_ready});
        end
        step();
        checks++; if ({ma_fault, dmem_req} !== 2'b00) begin failures++; $display("FAIL %s_after got fault/req=%b exp=00", name, {ma_fault, dmem_req}); end
    endtask

    task automatic test_timeout();
        drive_op(1'b1, 1'b0, 3'd2, 5'd8, 1'b1, 32'h200, 32'h0);
        step();
        ex_valid = 1'b0;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        step(); step(); step();
        checks++; if ({ma_fault, ex_ready} !== 2'b00) begin failures++; $display("FAIL timeout_early got fault/ready=%b exp=00", {ma_fault, ex_ready}); end
        step();
        checks++; if ({ma_fault, wen, ex_ready} !== 3'b101) begin failures++; $display("FAIL timeout_fault got fault/wen/ready=%b exp=101", {ma_fault, wen, ex_ready}); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_rvalid = 1'b0;
        checks++; if ({wen, ma_fault, dmem_req} !== 3'b000) begin failures++; $display("FAIL timeout_stray got wen/fault/req=%b exp=000", {wen, ma_fault, dmem_req}); end
    endtask

    task automatic test_reset_inflight();
        drive_op(1'b1, 1'b0, 3'd2, 5'd9, 1'b1, 32'h280, 32'h0);
        step();
        ex_valid = 1'b0;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        rst = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h9999_9999;
        step();
        rst = 1'b0;
        dmem_rvalid = 1'b0;
        #1;
        checks++; if ({dmem_req, wen, ma_fault, ma_rd_num, wdata, ex_ready} !== {3'b000, 5'd0, 32'd0, 1'b1}) begin
            failures++; $display("FAIL rst_inflight got req=%b wen=%b fault=%b rd=%0d wdata=%h ready=%b", dmem_req, wen, ma_fault, ma_rd_num, wdata, ex_ready);
        end
        drive_op(1'b1, 1'b0, 3'd2, 5'd0, 1'b1, 32'h300, 32'h0);
        step();
        ex_valid = 1'b0;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0055;
        step();
        dmem_rvalid = 1'b0;
        checks++; if ({wen, ma_fault, ex_ready} !== 3'b001) begin failures++; $display("FAIL lw_rd0 got wen/fault/ready=%b exp=001", {wen, ma_fault, ex_ready}); end
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_rd_num = 5'd0; ex_funct3 = 3'd0; ex_result = 32'd0; ex_store_data = 32'd0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_store("sb", 3'd0, 32'h103, 32'h0000_12AB, 4'b1000, 32'hABAB_ABAB, 2);
        test_store("sh", 3'd1, 32'h102, 32'hFFFF_1234, 4'b1100, 32'h1234_1234, 0);
        test_store("sw", 3'd2, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);
        test_load("lb", 3'd0, 32'h102, 32'h0080_0000, 32'hFFFF_FF80);
        test_load("lbu", 3'd4, 32'h102, 32'h0080_0000, 32'h0000_0080);
        test_load("lh", 3'd1, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
        test_load("lhu", 3'd5, 32'h102, 32'h8001_0000, 32'h0000_8001);
        test_load("lw", 3'd2, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        test_fault("lh_misaligned", 1'b1, 3'd1, 32'h101);
        test_fault("load_f3_3", 1'b1, 3'd3, 32'h100);
        test_fault("sw_misaligned", 1'b0, 3'd2, 32'h102);
        test_fault("store_f3_4", 1'b0, 3'd4, 32'h100);
        test_timeout();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
